// File: rtl/quad_encoder_gen_if.sv
// Step-command channel for quad_encoder_gen: direction + detent count over valid/ready.
interface quad_encoder_gen_if #(
  parameter int unsigned CNT_W = 8
);
  logic             Step_Valid;
  logic             Step_Ready;
  logic             Step_Dir;
  logic [CNT_W-1:0] Step_Count;

  modport master (output Step_Valid, output Step_Dir, output Step_Count, input Step_Ready);
  modport slave  (input Step_Valid, input Step_Dir, input Step_Count, output Step_Ready);
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature generator: drives Rot_A/Rot_B like a mechanical rotary encoder (rest level 11).
// Optional contact bounce on every line transition is enabled with `define QUAD_BOUNCE_EN.
module quad_encoder_gen #(
  parameter int unsigned PHASE_CYCLES   = 140000,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned BOUNCE_TOGGLES = 3,
  parameter int unsigned BOUNCE_CYCLES  = 20
) (
  input  logic               Fg_Clk,
  input  logic               RESET,
  quad_encoder_gen_if.slave  step,
  input  logic               Abort,
  output logic               Rot_A,
  output logic               Rot_B,
  output logic               Busy,
  output logic               Done,
  output logic [CNT_W-1:0]   Position
);

  localparam int unsigned DW = $clog2(PHASE_CYCLES + 1);
  localparam logic [DW-1:0] DwellLast = DW'(PHASE_CYCLES - 1);

  // Glitches must fit inside one phase dwell.
  if (BOUNCE_TOGGLES * BOUNCE_CYCLES >= PHASE_CYCLES) begin : g_bounce_cfg_check
    $error("quad_encoder_gen: BOUNCE_TOGGLES * BOUNCE_CYCLES must be < PHASE_CYCLES");
  end

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             abort_q, abort_d;
  logic [1:0]       rot_q, rot_d;
  logic [1:0]       pat_cur, pat_next;

  // {A,B} for one detent; CCW is the CW sequence with the channels swapped.
  function automatic logic [1:0] pattern(input logic dir, input logic [1:0] idx);
    logic [1:0] cw;
    unique case (idx)
      2'd0:    cw = 2'b10;
      2'd1:    cw = 2'b00;
      2'd2:    cw = 2'b01;
      default: cw = 2'b11;
    endcase
    return dir ? cw : {cw[0], cw[1]};
  endfunction

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    dwell_d  = dwell_q;
    remain_d = remain_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    abort_d  = abort_q;
    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (step.Step_Valid) begin
          dir_d    = step.Step_Dir;
          remain_d = step.Step_Count;
          phase_d  = 2'd0;
          dwell_d  = '0;
          state_d  = (step.Step_Count == '0) ? StFinish : StRun;
        end
      end
      StRun: begin
        abort_d = abort_q | Abort;
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          if (phase_q == 2'd3) begin
            if (remain_q != '0 && !(abort_q | Abort)) begin
              phase_d = 2'd0;
            end else begin
              state_d = StFinish;
            end
          end else begin
            phase_d = phase_q + 2'd1;
            // Entering 11 completes the detent.
            if (phase_q == 2'd2) begin
              pos_d    = dir_q ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
              remain_d = remain_q - CNT_W'(1);
            end
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      StFinish: begin
        state_d = StIdle;
        phase_d = 2'd0;
        dwell_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  assign pat_cur  = (state_q == StRun) ? pattern(dir_q, phase_q) : 2'b11;
  assign pat_next = (state_d == StRun) ? pattern(dir_d, phase_d) : 2'b11;

`ifdef QUAD_BOUNCE_EN
  localparam int unsigned LvlW = (BOUNCE_TOGGLES > 0) ? $clog2(BOUNCE_TOGGLES + 1) : 1;
  localparam int unsigned CycW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(BOUNCE_CYCLES - 1);

  logic [LvlW-1:0] lvl_q, lvl_d;
  logic [CycW-1:0] bcyc_q, bcyc_d;
  logic            odd_q, odd_d;
  logic [1:0]      old_q, old_d;

  // Glitch levels alternate new/old starting with new; odd levels show the pre-transition value.
  always_comb begin
    lvl_d  = lvl_q;
    bcyc_d = bcyc_q;
    odd_d  = odd_q;
    old_d  = old_q;
    if (pat_next != pat_cur) begin
      lvl_d  = LvlW'(BOUNCE_TOGGLES);
      bcyc_d = '0;
      odd_d  = 1'b0;
      old_d  = pat_cur;
    end else if (lvl_q != '0) begin
      if (bcyc_q == CycLast) begin
        bcyc_d = '0;
        lvl_d  = lvl_q - LvlW'(1);
        odd_d  = ~odd_q;
      end else begin
        bcyc_d = bcyc_q + CycW'(1);
      end
    end
    rot_d = (lvl_d != '0 && odd_d) ? old_d : pat_next;
  end

  always_ff @(posedge Fg_Clk or posedge RESET) begin
    if (RESET) begin
      lvl_q  <= '0;
      bcyc_q <= '0;
      odd_q  <= 1'b0;
      old_q  <= 2'b11;
    end else begin
      lvl_q  <= lvl_d;
      bcyc_q <= bcyc_d;
      odd_q  <= odd_d;
      old_q  <= old_d;
    end
  end
`else
  assign rot_d = pat_next;
`endif

  always_ff @(posedge Fg_Clk or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      phase_q  <= 2'd0;
      dwell_q  <= '0;
      remain_q <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      abort_q  <= 1'b0;
      rot_q    <= 2'b11;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      dwell_q  <= dwell_d;
      remain_q <= remain_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      abort_q  <= abort_d;
      rot_q    <= rot_d;
    end
  end

  assign Rot_A           = rot_q[1];
  assign Rot_B           = rot_q[0];
  assign Position        = pos_q;
  assign Busy            = (state_q != StIdle);
  assign Done            = (state_q == StFinish);
  assign step.Step_Ready = (state_q == StIdle);

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed + randomized bench for quad_encoder_gen against a per-cycle waveform model.
module tb_quad_encoder_gen;

  localparam int unsigned P  = 4;
  localparam int unsigned W  = 8;
  localparam int          DP = 4 * P;

  logic         Fg_Clk = 1'b0;
  logic         RESET;
  logic         Abort;
  logic         Rot_A, Rot_B, Busy, Done;
  logic [W-1:0] Position;

  quad_encoder_gen_if #(.CNT_W(W)) step_if ();

  quad_encoder_gen #(
    .PHASE_CYCLES  (P),
    .CNT_W         (W),
    .BOUNCE_TOGGLES(1),
    .BOUNCE_CYCLES (2)
  ) dut (
    .Fg_Clk  (Fg_Clk),
    .RESET   (RESET),
    .step    (step_if),
    .Abort   (Abort),
    .Rot_A   (Rot_A),
    .Rot_B   (Rot_B),
    .Busy    (Busy),
    .Done    (Done),
    .Position(Position)
  );

  always #5 Fg_Clk = ~Fg_Clk;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] model_pos;
  logic [1:0]   prev_rot;
  bit           prev_valid;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Detent sequences written out per direction, indexed by position within the detent.
  function automatic logic [1:0] ref_pattern(input bit dir, input int c);
    logic [1:0] cw_seq  [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
    logic [1:0] ccw_seq [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    int ph;
    ph = (c % DP) / P;
    return dir ? cw_seq[ph] : ccw_seq[ph];
  endfunction

  function automatic logic [W-1:0] exp_pos(input logic [W-1:0] p0, input bit dir, input int k);
    return dir ? p0 + W'(k) : p0 - W'(k);
  endfunction

  task automatic check_cycle(input string tag, input logic [1:0] rot, input logic [W-1:0] pos,
                             input bit busy, input bit done, input bit ready);
    logic [1:0] cur;
    cur = {Rot_A, Rot_B};
    check({tag, ".rot"},   32'(cur),                32'(rot));
    check({tag, ".pos"},   32'(Position),           32'(pos));
    check({tag, ".busy"},  32'(Busy),               32'(busy));
    check({tag, ".done"},  32'(Done),               32'(done));
    check({tag, ".ready"}, 32'(step_if.Step_Ready), 32'(ready));
    if (prev_valid) check({tag, ".gray"}, 32'((cur ^ prev_rot) == 2'b11), 32'(0));
    prev_rot   = cur;
    prev_valid = 1'b1;
  endtask

  // Caller is at the falling edge of an idle cycle; the command is accepted at the next edge.
  task automatic run_cmd(input bit dir, input int cnt, input int abort_at, input bit hold_valid);
    int           detents, runlen, k;
    logic [W-1:0] pos0;
    detents = cnt;
    if (abort_at >= 0 && abort_at / DP + 1 < cnt) detents = abort_at / DP + 1;
    runlen = detents * DP;
    pos0   = model_pos;
    step_if.Step_Valid = 1'b1;
    step_if.Step_Dir   = dir;
    step_if.Step_Count = W'(cnt);
    for (int c = 0; c <= runlen + 1; c++) begin
      @(negedge Fg_Clk);
      Abort = 1'b0;
      if (c < runlen) begin
        k = c / DP + (((c % DP) >= 3 * P) ? 1 : 0);
        check_cycle("run", ref_pattern(dir, c), exp_pos(pos0, dir, k), 1'b1, 1'b0, 1'b0);
      end else if (c == runlen) begin
        check_cycle("finish", 2'b11, exp_pos(pos0, dir, detents), 1'b1, 1'b1, 1'b0);
      end else begin
        check_cycle("idle", 2'b11, exp_pos(pos0, dir, detents), 1'b0, 1'b0, 1'b1);
      end
      if (!(hold_valid && c < runlen)) step_if.Step_Valid = 1'b0;
      if (c == abort_at) Abort = 1'b1;
    end
    model_pos = exp_pos(pos0, dir, detents);
  endtask

  initial begin
    int cnt, ab;
    RESET              = 1'b1;
    Abort              = 1'b0;
    step_if.Step_Valid = 1'b0;
    step_if.Step_Dir   = 1'b0;
    step_if.Step_Count = '0;
    model_pos          = '0;
    prev_valid         = 1'b0;
    repeat (2) @(negedge Fg_Clk);
    check_cycle("in_reset", 2'b11, '0, 1'b0, 1'b0, 1'b1);
    RESET = 1'b0;

    // Idle for 20 cycles; Abort while idle must do nothing.
    for (int i = 0; i < 20; i++) begin
      @(negedge Fg_Clk);
      check_cycle("reset_idle", 2'b11, '0, 1'b0, 1'b0, 1'b1);
      Abort = (i >= 5 && i < 8);
    end
    Abort = 1'b0;

    run_cmd(1'b1, 2, -1, 1'b0);          // CW x2: 0 -> 2
    run_cmd(1'b0, 2, -1, 1'b0);          // back to 0
    run_cmd(1'b0, 1, -1, 1'b0);          // 0 -> 255
    run_cmd(1'b1, 1, -1, 1'b0);          // 255 -> 0
    run_cmd(1'b1, 0, -1, 1'b0);          // zero-count command
    run_cmd(1'b1, 5, DP + P + 1, 1'b1);  // abort in detent 2 phase 1, valid held: 0 -> 2

    // Reset in the middle of the 00 phase of a CW command.
    step_if.Step_Valid = 1'b1;
    step_if.Step_Dir   = 1'b1;
    step_if.Step_Count = W'(3);
    for (int c = 0; c <= P + 1; c++) begin
      @(negedge Fg_Clk);
      step_if.Step_Valid = 1'b0;
      check_cycle("pre_reset", ref_pattern(1'b1, c), model_pos, 1'b1, 1'b0, 1'b0);
    end
    #1 RESET = 1'b1;
    #1;
    prev_valid = 1'b0;
    check_cycle("async_reset", 2'b11, '0, 1'b0, 1'b0, 1'b1);
    @(negedge Fg_Clk);
    RESET     = 1'b0;
    model_pos = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Fg_Clk);
      check_cycle("post_reset", 2'b11, '0, 1'b0, 1'b0, 1'b1);
    end

    // Randomized back-to-back commands.
    for (int n = 0; n < 8; n++) begin
      cnt = int'($urandom_range(0, 3));
      ab  = -1;
      if (cnt > 0 && $urandom_range(0, 1) == 1) ab = int'($urandom_range(0, cnt * DP - 1));
      run_cmd(1'($urandom_range(0, 1)), cnt, ab, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
